// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: segment bit positions,
// lit-mask encodings of the hex glyphs and the capture FSM state type.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_LIT_0 = 7'h7E;
    localparam logic [6:0] SEG_LIT_1 = 7'h30;
    localparam logic [6:0] SEG_LIT_2 = 7'h6D;
    localparam logic [6:0] SEG_LIT_3 = 7'h79;
    localparam logic [6:0] SEG_LIT_4 = 7'h33;
    localparam logic [6:0] SEG_LIT_5 = 7'h5B;
    localparam logic [6:0] SEG_LIT_6 = 7'h5F;
    localparam logic [6:0] SEG_LIT_7 = 7'h70;
    localparam logic [6:0] SEG_LIT_8 = 7'h7F;
    localparam logic [6:0] SEG_LIT_9 = 7'h7B;
    localparam logic [6:0] SEG_LIT_A = 7'h77;
    localparam logic [6:0] SEG_LIT_B = 7'h1F;
    localparam logic [6:0] SEG_LIT_C = 7'h4E;
    localparam logic [6:0] SEG_LIT_D = 7'h3D;
    localparam logic [6:0] SEG_LIT_E = 7'h4F;
    localparam logic [6:0] SEG_LIT_F = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seg7_state_t;

    // Active-low bus to lit mask, placing each segment at its named position.
    function automatic logic [6:0] seg_lit(input logic [6:0] seg_n);
        logic [6:0] lit;
        lit        = '0;
        lit[SEG_A] = !seg_n[SEG_A];
        lit[SEG_B] = !seg_n[SEG_B];
        lit[SEG_C] = !seg_n[SEG_C];
        lit[SEG_D] = !seg_n[SEG_D];
        lit[SEG_E] = !seg_n[SEG_E];
        lit[SEG_F] = !seg_n[SEG_F];
        lit[SEG_G] = !seg_n[SEG_G];
        return lit;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: active-low pattern
// in, hex value plus blank / unrecognised flags out.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output logic [3:0] o_hex,
    output logic       o_blank,
    output logic       o_err
);

    logic [6:0] w_lit;

    always_comb begin
        w_lit   = seg_lit(i_seg_n);
        o_hex   = 4'h0;
        o_blank = 1'b0;
        o_err   = 1'b0;
        case (w_lit)
            SEG_LIT_0: o_hex = 4'h0;
            SEG_LIT_1: o_hex = 4'h1;
            SEG_LIT_2: o_hex = 4'h2;
            SEG_LIT_3: o_hex = 4'h3;
            SEG_LIT_4: o_hex = 4'h4;
            SEG_LIT_5: o_hex = 4'h5;
            SEG_LIT_6: o_hex = 4'h6;
            SEG_LIT_7: o_hex = 4'h7;
            SEG_LIT_8: o_hex = 4'h8;
            SEG_LIT_9: o_hex = 4'h9;
            SEG_LIT_A: o_hex = 4'hA;
            SEG_LIT_B: o_hex = 4'hB;
            SEG_LIT_C: o_hex = 4'hC;
            SEG_LIT_D: o_hex = 4'hD;
            SEG_LIT_E: o_hex = 4'hE;
            SEG_LIT_F: o_hex = 4'hF;
            SEG_BLANK: o_blank = 1'b1;
            default:   o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// Samples a multiplexed active-low 7-segment display, decodes each settled
// digit and publishes full-display snapshots. Option: SEG7_DP_CAPTURE_EN.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     an_n,
`ifdef SEG7_DP_CAPTURE_EN
    input  logic                dp_n,
    output logic [NDIG-1:0]     dig_dp,
    output logic [NDIG-1:0]     frame_dp,
`endif
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_blank,
    output logic [NDIG-1:0]     dig_err,
    output logic [4*NDIG-1:0]   frame_data,
    output logic                frame_err,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [1:0]          dbg_state
);

`ifdef SEG7_DP_CAPTURE_EN
    localparam int DPW = 1;
`else
    localparam int DPW = 0;
`endif
    localparam int SW = NDIG + 7 + DPW;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

    logic [SW-1:0]     w_in;
    logic [SW-1:0]     r_sync1;
    logic [SW-1:0]     r_sync2;
    logic [SW-1:0]     r_prev;
    logic [7:0]        r_cnt;
    seg7_state_t       r_state;
    seg7_state_t       w_next;
    logic              w_capture;
    logic              w_changed;
    logic              w_stable;
    logic [3:0]        w_low_cnt;
    logic [3:0]        w_idx;
    logic              w_one_low;
    logic [NDIG-1:0]   w_prev_an;
    logic [3:0]        w_hex;
    logic              w_blank;
    logic              w_err;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_dig_blank;
    logic [NDIG-1:0]   r_dig_err;
    logic [NDIG-1:0]   r_seen;
    logic [NDIG-1:0]   w_seen_nxt;
    logic              w_load;
    logic [4*NDIG-1:0] r_frame_data;
    logic              r_frame_err;
    logic              r_frame_valid;

`ifdef SEG7_DP_CAPTURE_EN
    logic [NDIG-1:0]   r_dig_dp;
    logic [NDIG-1:0]   r_frame_dp;
    assign w_in     = {dp_n, an_n, seg_n};
    assign dig_dp   = r_dig_dp;
    assign frame_dp = r_frame_dp;
`else
    assign w_in = {an_n, seg_n};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_next;
            if (w_changed)
                r_cnt <= '0;
            else if (r_cnt < STABLE_MAX)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_changed = (r_sync2 != r_prev);
    assign w_stable  = (r_cnt >= STABLE_MAX - 8'd1);
    assign w_prev_an = r_prev[NDIG+6:7];

    always_comb begin
        w_low_cnt = '0;
        w_idx     = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!w_prev_an[i]) begin
                w_low_cnt = w_low_cnt + 4'd1;
                w_idx     = 4'(i);
            end
        end
    end
    assign w_one_low = (w_low_cnt == 4'd1);

    seg7_pattern_decode u_decode (
        .i_seg_n (r_prev[6:0]),
        .o_hex   (w_hex),
        .o_blank (w_blank),
        .o_err   (w_err)
    );

    // A zero counter in HOLD means the bus moved on the capture edge itself,
    // so the new pair must be re-qualified rather than waiting for another change.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_one_low)
                    w_next = SETTLE;
            end
            SETTLE: begin
                if (!w_one_low) begin
                    w_next = IDLE;
                end else if (w_stable) begin
                    w_capture = 1'b1;
                    w_next    = HOLD;
                end
            end
            HOLD: begin
                if (w_changed || (r_cnt == 8'd0))
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits    <= '0;
            r_dig_blank <= '1;
            r_dig_err   <= '0;
`ifdef SEG7_DP_CAPTURE_EN
            r_dig_dp    <= '0;
`endif
        end else if (w_capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_idx == 4'(i)) begin
                    r_digits[4*i +: 4] <= w_hex;
                    r_dig_blank[i]     <= w_blank;
                    r_dig_err[i]       <= w_err;
`ifdef SEG7_DP_CAPTURE_EN
                    r_dig_dp[i]        <= !r_prev[SW-1];
`endif
                end
            end
        end
    end

    // Frame handshake: frame_valid holds with frame_data/frame_err stable until
    // a cycle with frame_valid & frame_ready; it drops on the following edge.
    // A capture landing on the seen-clear edge keeps its bit.
    assign w_load = (&r_seen) && !r_frame_valid;

    always_comb begin
        w_seen_nxt = w_load ? '0 : r_seen;
        for (int i = 0; i < NDIG; i++) begin
            if (w_capture && (w_idx == 4'(i)))
                w_seen_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen        <= '0;
            r_frame_data  <= '0;
            r_frame_err   <= 1'b0;
            r_frame_valid <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            r_frame_dp    <= '0;
`endif
        end else begin
            r_seen <= w_seen_nxt;
            if (w_load) begin
                r_frame_data  <= r_digits;
                r_frame_err   <= |r_dig_err;
                r_frame_valid <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                r_frame_dp    <= r_dig_dp;
`endif
            end else if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign digits      = r_digits;
    assign dig_blank   = r_dig_blank;
    assign dig_err     = r_dig_err;
    assign frame_data  = r_frame_data;
    assign frame_err   = r_frame_err;
    assign frame_valid = r_frame_valid;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: drives scanned digit patterns and
// scores every accepted frame against an expected-frame queue.
module tb_seg7_readback;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;
    localparam int HOLD_CYC   = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dig_blank;
    logic [NDIG-1:0]   dig_err;
    logic [4*NDIG-1:0] frame_data;
    logic              frame_err;
    logic              frame_valid;
    logic              frame_ready;
    logic [1:0]        dbg_state;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_frames = 0;
    logic [16:0] exp_q[$];

    // Lit masks (a..g, 1 = lit) for hex 0..F.
    logic [6:0] lit_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_readback #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .digits      (digits),
        .dig_blank   (dig_blank),
        .dig_err     (dig_err),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop one expected frame per accepted handshake.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            n_frames++;
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("frame", {15'd0, frame_err, frame_data}, {15'd0, e});
            end
        end
    end

    // Drivers are entered and leave 1 time unit after a rising edge.
    task automatic drive(input logic [3:0] an, input logic [6:0] lit, input int n);
        an_n  = an;
        seg_n = ~lit;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h00, n);
    endtask

    task automatic scan(input logic [6:0] l0, input logic [6:0] l1,
                        input logic [6:0] l2, input logic [6:0] l3);
        drive(4'b1110, l0, HOLD_CYC);
        drive(4'b1101, l1, HOLD_CYC);
        drive(4'b1011, l2, HOLD_CYC);
        drive(4'b0111, l3, HOLD_CYC);
        idle(4);
    endtask

    task automatic no_valid_window(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (frame_valid) hits++;
        end
        check(tag, 32'(hits), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL timeout: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n       = 1'b0;
        seg_n       = 7'h7F;
        an_n        = 4'hF;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_blank", 32'(dig_blank), 32'hF);
        check("rst_err", 32'(dig_err), 32'h0);
        check("rst_fvalid", 32'(frame_valid), 32'h0);
        check("rst_fdata", 32'(frame_data), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        rst_n = 1'b1;
        no_valid_window("no_fv_after_release", 2 + STABLE_CYC + 2);

        // Basic scan 1,A,7,F.
        exp_q.push_back({1'b0, 16'hF7A1});
        scan(lit_tab[1], lit_tab[10], lit_tab[7], lit_tab[15]);
        check("scan1_digits", 32'(digits), 32'hF7A1);
        check("scan1_blank", 32'(dig_blank), 32'h0);
        check("scan1_err", 32'(dig_err), 32'h0);
        check("scan1_drain", 32'(exp_q.size()), 32'd0);

        // Digit 2 held one sample short: no capture, so no frame until a real one.
        drive(4'b1011, lit_tab[8], STABLE_CYC - 1);
        idle(6);
        check("short_d2", 32'(digits[11:8]), 32'h7);
        drive(4'b1110, lit_tab[0], HOLD_CYC);
        drive(4'b1101, lit_tab[2], HOLD_CYC);
        drive(4'b0111, lit_tab[4], HOLD_CYC);
        idle(6);
        check("short_no_frame", 32'(frame_valid), 32'h0);
        exp_q.push_back({1'b0, 16'h4820});
        drive(4'b1011, lit_tab[8], HOLD_CYC);
        idle(4);
        check("short_digits", 32'(digits), 32'h4820);
        check("short_drain", 32'(exp_q.size()), 32'd0);

        // Unrecognised pattern on digit 1, then blank.
        exp_q.push_back({1'b1, 16'hC503});
        scan(lit_tab[3], 7'h01, lit_tab[5], lit_tab[12]);
        check("err_flags", 32'(dig_err), 32'h2);
        check("err_value", 32'(digits[7:4]), 32'h0);
        check("err_digits", 32'(digits), 32'hC503);
        drive(4'b1101, 7'h00, HOLD_CYC);
        idle(4);
        check("blank_flags", 32'(dig_blank), 32'h2);
        check("blank_err", 32'(dig_err), 32'h0);

        // Backpressure: first snapshot held while live digits move on.
        frame_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h8642});
        scan(lit_tab[2], lit_tab[4], lit_tab[6], lit_tab[8]);
        check("bp_valid", 32'(frame_valid), 32'h1);
        check("bp_data", 32'(frame_data), 32'h8642);
        exp_q.push_back({1'b0, 16'hEDB9});
        scan(lit_tab[9], lit_tab[11], lit_tab[13], lit_tab[14]);
        check("bp_data_held", 32'(frame_data), 32'h8642);
        check("bp_live", 32'(digits), 32'hEDB9);
        frame_ready = 1'b1;
        idle(8);
        check("bp_drain", 32'(exp_q.size()), 32'd0);
        check("bp_valid_low", 32'(frame_valid), 32'h0);

        // Two anodes low: ignored.
        drive(4'b1100, lit_tab[8], 20);
        idle(4);
        check("multi_digits", 32'(digits), 32'hEDB9);
        check("multi_err", 32'(dig_err), 32'h0);
        check("multi_fvalid", 32'(frame_valid), 32'h0);

        // Reset with a frame pending and a digit mid-settle.
        frame_ready = 1'b0;
        scan(lit_tab[1], lit_tab[2], lit_tab[3], lit_tab[4]);
        check("pend_valid", 32'(frame_valid), 32'h1);
        drive(4'b1110, lit_tab[5], 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_fvalid", 32'(frame_valid), 32'h0);
        check("arst_digits", 32'(digits), 32'h0);
        check("arst_blank", 32'(dig_blank), 32'hF);
        check("arst_fdata", 32'(frame_data), 32'h0);
        check("arst_state", 32'(dbg_state), 32'h0);
        @(posedge clk);
        #1;
        an_n        = 4'hF;
        seg_n       = 7'h7F;
        frame_ready = 1'b1;
        rst_n       = 1'b1;
        no_valid_window("arst_discard", 2 + STABLE_CYC + 4);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(n_frames), 32'd5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Receiving end of the active-low 7-segment interface driven by the hex-to-segment encoder and display scanner.
- Samples the multiplexed segment bus and digit-enable lines, waits for each digit's pattern to settle, and decodes it back to a 4-bit hex value per digit.
- Assembles one snapshot of all digits into a frame and presents it on a valid/ready handshake.
- Used for display self-check and loopback test in the lab top level.

Parameters:
- NDIG, 4: number of multiplexed digits, 1..8.
- STABLE_CYC, 4: consecutive identical synchronized samples required before capture, 2..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  7  segments, active-low (0 = lit); bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- an_n  in  NDIG  digit enables, active-low; bit i = digit i.
- digits  out  4*NDIG  live decoded values; digit i at [4i+3:4i].
- dig_blank  out  NDIG  last capture of digit i had all segments off.
- dig_err  out  NDIG  last capture of digit i matched no table entry and was not blank.
- frame_data  out  4*NDIG  snapshot of digits taken when frame_valid rises.
- frame_err  out  1  OR of dig_err at snapshot time.
- frame_valid  out  1  snapshot available.
- frame_ready  in  1  consumer accepts the snapshot.

Behaviour:
- Reset (async assert, sync release):
  - synchronizer stages load seg_n=7'h7F and an_n=all ones.
  - digits, frame_data, dig_err, frame_err and frame_valid = 0; dig_blank = all ones.
  - seen mask = 0, stability counter = 0, FSM = IDLE.
- Input path: {an_n, seg_n} goes through a 2-flop synchronizer, giving sample s; s_prev = s delayed one cycle.
- Stability counter:
  - cleared when s != s_prev, otherwise increments, saturating at STABLE_CYC.
  - the pair counts as stable when the counter is >= STABLE_CYC-1, i.e. STABLE_CYC identical samples.
- FSM:
  - IDLE: go to SETTLE when s_prev has exactly one an_n bit low.
  - SETTLE: return to IDLE if the anode count != 1. When stable, capture: write the decoder result to digit k (the low anode), update dig_blank[k] and dig_err[k], set seen[k], go to HOLD.
  - HOLD: go to IDLE on any change of s. Exactly one capture per settled pair.
- Decode table (lit masks, a..g):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - blank (mask 00): value 0, blank=1.
  - any other mask: value 0, err=1.
- Latency: seg/an change to digits update = 2 + STABLE_CYC cycles.
- Frame:
  - when seen == all ones and frame_valid=0: on the next edge load frame_data/frame_err from the current digits, set frame_valid, clear seen.
  - frame_valid and frame_data stay constant until the cycle with frame_valid & frame_ready; frame_valid drops on the next edge.
  - live captures continue while a frame is pending and accumulate into seen.
  - a capture in the same cycle as the seen clear (or as a handshake) leaves its bit set: capture wins.
- Multiple or zero anodes low: no capture, no error.
- Reset mid-frame: the pending frame is discarded.

Optional Feature:
- Macro SEG7_DP_CAPTURE_EN.
- When defined, add:
  - port dp_n (in, 1, active-low decimal point), synchronized alongside seg_n and included in the stability compare.
  - port dig_dp (out, NDIG), reset 0, captured with each digit.
  - port frame_dp (out, NDIG), snapshotted with frame_data.
- When undefined: these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg holds:
  - SEG_LIT_0..SEG_LIT_F and SEG_BLANK constants, in the 7-bit lit-mask encoding above.
  - the FSM state typedef (IDLE, SETTLE, HOLD).
  - the bit-position constants for a..g.
- Sub-module seg7_pattern_decode: combinational; 7-bit active-low pattern in; hex[3:0], blank and err out.

Test Plan:
- Reset with rst_n=0 mid-stream -> all outputs at their reset values immediately (async); no frame_valid for 2+STABLE_CYC cycles after release.
- Scan digits 0..3 with patterns for 1, A, 7, F, each held 8 cycles, frame_ready=1 -> digits=16'hF7A1; frame_valid pulses 1 cycle with frame_data=16'hF7A1 and frame_err=0.
- Hold the digit-2 pattern for only STABLE_CYC-1 identical samples -> no capture; digits[11:8] and seen[2] unchanged.
- Drive digit 1 with lit mask 0x01 (g only) -> dig_err[1]=1; digits[7:4]=0; the following frame has frame_err=1. Drive 0x00 -> dig_blank[1]=1, dig_err[1]=0.
- frame_ready=0 while the scan continues with new values -> frame_data stays at the first snapshot; after the handshake a second frame appears carrying the later values.
- an_n=4'b1100 (two anodes low) with valid segments for 20 cycles -> no capture, no dig_err change.
